// File: rtl/hysteresis_edge_reader_pkg.sv
// Shared image geometry for the hysteresis/hough pipeline and the reader state type.
// Also provides the helper that sizes counters and buses from this geometry.
package hysteresis_edge_reader_pkg;

  localparam int WIDTH              = 64;
  localparam int HEIGHT             = 48;
  localparam int REDUCED_WIDTH      = 4;
  localparam int REDUCED_HEIGHT     = 3;
  localparam int REDUCED_IMAGE_SIZE = REDUCED_WIDTH * REDUCED_HEIGHT;
  localparam int STARTING_X         = 10;
  localparam int STARTING_Y         = 20;

  // $clog2 that never returns 0, so degenerate sizes still give a 1-bit bus
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ADDR_W = clog2_min1(REDUCED_IMAGE_SIZE);
  localparam int X_W    = clog2_min1(WIDTH);
  localparam int Y_W    = clog2_min1(HEIGHT);
  localparam int CNT_W  = clog2_min1(REDUCED_IMAGE_SIZE + 1);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_SCAN  = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } reader_state_e;

endpackage

// File: rtl/hysteresis_edge_reader_if.sv
// BRAM read port plus hough vote FIFO push port as seen by the edge reader.
// master = reader side, slave = memory/FIFO side.
interface hysteresis_edge_reader_if
  import hysteresis_edge_reader_pkg::*;
#(
  parameter int P_ADDR_W = ADDR_W,
  parameter int P_X_W    = X_W,
  parameter int P_Y_W    = Y_W
) ();

  logic                rd_en;
  logic [P_ADDR_W-1:0] rd_addr;
  logic [7:0]          rd_data;
  logic                out_full;
  logic                out_wr_en;
  logic [P_X_W-1:0]    out_x;
  logic [P_Y_W-1:0]    out_y;

  modport master (
    output rd_en, rd_addr, out_wr_en, out_x, out_y,
    input  rd_data, out_full
  );

  modport slave (
    input  rd_en, rd_addr, out_wr_en, out_x, out_y,
    output rd_data, out_full
  );

endinterface

// File: rtl/hysteresis_edge_reader_raster_addr_gen.sv
// Raster-order address/column/row counter; advances one pixel per enabled cycle.
// o_last flags that the current address is the final pixel of the region.
module hysteresis_edge_reader_raster_addr_gen
  import hysteresis_edge_reader_pkg::*;
#(
  parameter int COLS   = 4,
  parameter int ROWS   = 3,
  parameter int A_W    = 4,
  parameter int COL_W  = 2,
  parameter int ROW_W  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [A_W-1:0]   o_addr,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_last
);

  logic [A_W-1:0]   r_addr;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (i_en) begin
      r_addr <= r_addr + A_W'(1);
      if (r_col == COL_W'(COLS - 1)) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_addr = r_addr;
  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = (r_addr == A_W'(COLS * ROWS - 1));

endmodule

// File: rtl/hysteresis_edge_reader.sv
// Scans the hysteresis BRAM in raster order and pushes full-image (x,y) of every
// edge pixel into the hough vote FIFO, stalling the read pipe on FIFO full.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RD_IDLE  | waiting for start
//   RD_SCAN  | issuing one BRAM address per cycle unless stalled
//   RD_DRAIN | all addresses issued; waiting for last pixel to be taken
//   RD_DONE  | one-cycle done pulse, then back to idle
module hysteresis_edge_reader
  import hysteresis_edge_reader_pkg::*;
#(
  parameter int REDUCED_WIDTH  = hysteresis_edge_reader_pkg::REDUCED_WIDTH,
  parameter int REDUCED_HEIGHT = hysteresis_edge_reader_pkg::REDUCED_HEIGHT,
  parameter int STARTING_X     = hysteresis_edge_reader_pkg::STARTING_X,
  parameter int STARTING_Y     = hysteresis_edge_reader_pkg::STARTING_Y,
  parameter int WIDTH          = hysteresis_edge_reader_pkg::WIDTH,
  parameter int HEIGHT         = hysteresis_edge_reader_pkg::HEIGHT,
  parameter int EDGE_THRESHOLD = 0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  hysteresis_edge_reader_if.master           bus,
  output logic                               busy,
  output logic                               done,
  output logic [clog2_min1(REDUCED_WIDTH*REDUCED_HEIGHT+1)-1:0] edge_count
);

  localparam int P      = REDUCED_WIDTH * REDUCED_HEIGHT;
  localparam int L_A_W  = clog2_min1(P);
  localparam int L_C_W  = clog2_min1(REDUCED_WIDTH);
  localparam int L_R_W  = clog2_min1(REDUCED_HEIGHT + 1);
  localparam int L_X_W  = clog2_min1(WIDTH);
  localparam int L_Y_W  = clog2_min1(HEIGHT);
  localparam int L_N_W  = clog2_min1(P + 1);

  reader_state_e r_state;
  reader_state_e w_next;

  logic             r_v1;
  logic [L_X_W-1:0] r_x1;
  logic [L_Y_W-1:0] r_y1;
  logic [L_N_W-1:0] r_edge_count;

  logic             w_pass;
  logic             w_stall;
  logic             w_push;
  logic             w_rd_en;
  logic             w_clr;
  logic             w_busy;
  logic             w_done;
  logic             w_last;
  logic [L_A_W-1:0] w_addr;
  logic [L_C_W-1:0] w_col;
  logic [L_R_W-1:0] w_row;

  hysteresis_edge_reader_raster_addr_gen #(
    .COLS  (REDUCED_WIDTH),
    .ROWS  (REDUCED_HEIGHT),
    .A_W   (L_A_W),
    .COL_W (L_C_W),
    .ROW_W (L_R_W)
  ) u_addr_gen (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (w_rd_en),
    .o_addr (w_addr),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_last (w_last)
  );

  // rd_data is only meaningful while v1 marks it as holding pixel (x1,y1)
  assign w_pass  = r_v1 && (bus.rd_data > 8'(EDGE_THRESHOLD));
  assign w_stall = w_pass && bus.out_full;
  assign w_push  = w_pass && !bus.out_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    w_clr   = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      RD_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_clr  = 1'b1;
          w_next = RD_SCAN;
        end
      end
      RD_SCAN: begin
        w_rd_en = !w_stall;
        if (w_rd_en && w_last) begin
          w_next = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (r_v1 && !w_stall) begin
          w_next = RD_DONE;
        end
      end
      RD_DONE: begin
        w_done = 1'b1;
        w_next = RD_IDLE;
      end
      default: begin
        w_next = RD_IDLE;
      end
    endcase
  end

  // A stalled pixel keeps v1 and its coordinates until the FIFO takes it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1         <= 1'b0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_edge_count <= '0;
    end else begin
      if (w_rd_en) begin
        r_v1 <= 1'b1;
        r_x1 <= L_X_W'(w_col) + L_X_W'(STARTING_X);
        r_y1 <= L_Y_W'(w_row) + L_Y_W'(STARTING_Y);
      end else if (!w_stall) begin
        r_v1 <= 1'b0;
      end
      if (w_clr) begin
        r_edge_count <= '0;
      end else if (w_push) begin
        r_edge_count <= r_edge_count + L_N_W'(1);
      end
    end
  end

  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = w_addr;
  assign bus.out_wr_en = w_push;
  assign bus.out_x     = r_x1;
  assign bus.out_y     = r_y1;
  assign busy          = w_busy;
  assign done          = w_done;
  assign edge_count    = r_edge_count;

endmodule

// File: tb/tb_hysteresis_edge_reader.sv
// Bench for hysteresis_edge_reader: two instances (threshold 0 and 50) sharing start/reset,
// each with its own BRAM model and a raster-order push scoreboard.
module tb_hysteresis_edge_reader;
  import hysteresis_edge_reader_pkg::*;

  localparam int P = REDUCED_IMAGE_SIZE;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  hysteresis_edge_reader_if ifa ();
  hysteresis_edge_reader_if ifb ();

  logic             busy_a, done_a, busy_b, done_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  hysteresis_edge_reader #(.EDGE_THRESHOLD(0)) dut_a (
    .clock(clock), .reset(reset), .start(start), .bus(ifa.master),
    .busy(busy_a), .done(done_a), .edge_count(cnt_a)
  );

  hysteresis_edge_reader #(.EDGE_THRESHOLD(50)) dut_b (
    .clock(clock), .reset(reset), .start(start), .bus(ifb.master),
    .busy(busy_b), .done(done_b), .edge_count(cnt_b)
  );

  logic [7:0] mem_a [P];
  logic [7:0] mem_b [P];

  always @(posedge clock) if (ifa.rd_en) ifa.rd_data <= mem_a[ifa.rd_addr];
  always @(posedge clock) if (ifb.rd_en) ifb.rd_data <= mem_b[ifb.rd_addr];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  int qa_x[$], qa_y[$], qb_x[$], qb_y[$];
  int la_x[$], la_y[$], la_c[$], lb_x[$], lb_y[$];
  int exp_cnt_a, exp_cnt_b;
  int scan_c0;

  // Expected pushes straight from the image: every pixel above threshold, raster order
  task automatic load_model();
    qa_x.delete(); qa_y.delete(); qb_x.delete(); qb_y.delete();
    la_x.delete(); la_y.delete(); la_c.delete(); lb_x.delete(); lb_y.delete();
    for (int i = 0; i < P; i++) begin
      if (int'(mem_a[i]) > 0) begin
        qa_x.push_back(STARTING_X + i % REDUCED_WIDTH);
        qa_y.push_back(STARTING_Y + i / REDUCED_WIDTH);
      end
      if (int'(mem_b[i]) > 50) begin
        qb_x.push_back(STARTING_X + i % REDUCED_WIDTH);
        qb_y.push_back(STARTING_Y + i / REDUCED_WIDTH);
      end
    end
    exp_cnt_a = qa_x.size();
    exp_cnt_b = qb_x.size();
  endtask

  always @(negedge clock) begin
    int ex, ey;
    if (!reset) begin
      if (ifa.out_full) check("a_no_push_while_full", int'(ifa.out_wr_en), 0);
      if (ifa.out_wr_en) begin
        la_x.push_back(int'(ifa.out_x)); la_y.push_back(int'(ifa.out_y)); la_c.push_back(cyc);
        check("a_push_expected", int'(qa_x.size() > 0), 1);
        if (qa_x.size() > 0) begin
          ex = qa_x.pop_front(); ey = qa_y.pop_front();
          check("a_out_x", int'(ifa.out_x), ex);
          check("a_out_y", int'(ifa.out_y), ey);
        end
      end
      if (ifb.out_wr_en) begin
        lb_x.push_back(int'(ifb.out_x)); lb_y.push_back(int'(ifb.out_y));
        check("b_push_expected", int'(qb_x.size() > 0), 1);
        if (qb_x.size() > 0) begin
          ex = qb_x.pop_front(); ey = qb_y.pop_front();
          check("b_out_x", int'(ifb.out_x), ex);
          check("b_out_y", int'(ifb.out_y), ey);
        end
      end
    end
  end

  // mode 0: no backpressure; 1: full during C+4..C+7; 2: full during C+13..C+17 (DRAIN)
  task automatic run_scan(input int mode, input int exp_done_off);
    int off;
    int got_done;
    load_model();
    @(posedge clock); #1;
    start = 1'b1;
    scan_c0 = cyc;
    got_done = 0;
    off = 0;
    for (int k = 1; k <= 60 && got_done == 0; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      off = cyc - scan_c0;
      ifa.out_full = (mode == 1 && off >= 4 && off <= 7) || (mode == 2 && off >= 13 && off <= 17);
      @(negedge clock);
      if (off == 1) check("rd_addr_first", int'(ifa.rd_addr), 0);
      if (off <= exp_done_off) check("busy_in_scan", int'(busy_a), 1);
      if (mode == 1 && off >= 4 && off <= 7) begin
        check("stall_rd_en", int'(ifa.rd_en), 0);
        check("stall_rd_addr", int'(ifa.rd_addr), 3);
      end
      if (done_a) got_done = 1;
    end
    check("done_seen", got_done, 1);
    check("done_cycle", off, exp_done_off);
    check("a_queue_drained", qa_x.size(), 0);
    check("b_queue_drained", qb_x.size(), 0);
    check("a_edge_count", int'(cnt_a), exp_cnt_a);
    check("b_edge_count", int'(cnt_b), exp_cnt_b);
    ifa.out_full = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("done_one_cycle", int'(done_a), 0);
    check("idle_after_done", int'(busy_a), 0);
    check("a_edge_count_hold", int'(cnt_a), exp_cnt_a);
  endtask

  task automatic reset_test();
    int dones;
    load_model();
    @(posedge clock); #1;
    start = 1'b1;
    scan_c0 = cyc;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
    end
    check("rst_pre_addr", int'(ifa.rd_addr), 6);
    check("rst_pre_busy", int'(busy_a), 1);
    #2;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("rst_rd_en", int'(ifa.rd_en), 0);
    check("rst_wr_en", int'(ifa.out_wr_en), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_rd_addr", int'(ifa.rd_addr), 0);
    check("rst_edge_count", int'(cnt_a), 0);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done_a || ifa.out_wr_en || busy_a) dones++;
    end
    check("rst_quiet_after", dones, 0);
  endtask

  initial begin
    for (int i = 0; i < P; i++) begin
      mem_a[i] = 8'd0;
      mem_b[i] = 8'd0;
    end
    mem_b[2] = 8'd50;
    mem_b[7] = 8'd51;
    ifa.out_full = 1'b0;
    ifb.out_full = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_rd_en", int'(ifa.rd_en), 0);
    check("reset_wr_en", int'(ifa.out_wr_en), 0);
    check("reset_busy", int'(busy_a), 0);
    check("reset_done", int'(done_a), 0);
    check("reset_rd_addr", int'(ifa.rd_addr), 0);
    check("reset_edge_count", int'(cnt_a), 0);
    reset = 1'b0;

    // all-zero image
    run_scan(0, 14);
    check("zero_pushes", la_x.size(), 0);
    check("b_pushes", lb_x.size(), 1);
    if (lb_x.size() == 1) begin
      check("b_x_lit", lb_x[0], 13);
      check("b_y_lit", lb_y[0], 21);
    end

    // pixels 0, 5, 11
    mem_a[0] = 8'd7; mem_a[5] = 8'd1; mem_a[11] = 8'd3;
    run_scan(0, 14);
    check("sparse_pushes", la_x.size(), 3);
    if (la_x.size() == 3) begin
      check("p0_x", la_x[0], 10); check("p0_y", la_y[0], 20); check("p0_c", la_c[0] - scan_c0, 2);
      check("p1_x", la_x[1], 11); check("p1_y", la_y[1], 21); check("p1_c", la_c[1] - scan_c0, 7);
      check("p2_x", la_x[2], 13); check("p2_y", la_y[2], 22); check("p2_c", la_c[2] - scan_c0, 13);
    end

    // all 255 with a 4-cycle stall
    for (int i = 0; i < P; i++) mem_a[i] = 8'd255;
    run_scan(1, 18);
    check("full_pushes", la_x.size(), 12);
    if (la_x.size() == 12) begin
      check("resume_c", la_c[2] - scan_c0, 8);
      check("last_x", la_x[11], 13);
      check("last_y", la_y[11], 22);
    end

    // only pixel 11, FIFO full through part of DRAIN
    for (int i = 0; i < P; i++) mem_a[i] = 8'd0;
    mem_a[11] = 8'd200;
    run_scan(2, 19);
    check("drain_pushes", la_x.size(), 1);
    if (la_x.size() == 1) begin
      check("drain_x", la_x[0], 13);
      check("drain_y", la_y[0], 22);
      check("drain_c", la_c[0] - scan_c0, 18);
    end

    // reset mid-scan, then rescan
    for (int i = 0; i < P; i++) mem_a[i] = 8'd255;
    reset_test();
    for (int i = 0; i < P; i++) mem_a[i] = 8'd0;
    mem_a[5] = 8'd9;
    run_scan(0, 14);
    check("rescan_pushes", la_x.size(), 1);
    if (la_x.size() == 1) begin
      check("rescan_x", la_x[0], 11);
      check("rescan_y", la_y[0], 21);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
